// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and the control stage.
// The state encodings are fixed because the control stage decodes them directly.
package pc_sequencer_pkg;

  localparam int PC_WIDTH = 10;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IN = 2'b01,
    HALT    = 2'b10
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_flag_register.sv
// Registered ALU zero/negative flags, loaded on the enable strobe in every state.
module flagRegister (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic zero_in,
  input  logic negative_in,
  output logic zero_out,
  output logic negative_out
);

  logic zero_q, zero_d;
  logic negative_q, negative_d;

  always_comb begin
    zero_d     = zero_q;
    negative_d = negative_q;
    if (enable) begin
      zero_d     = zero_in;
      negative_d = negative_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign zero_out     = zero_q;
  assign negative_out = negative_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: RUN / WAIT_IN / HALT control with branch, jump,
// input-wait and halt handling. Branches test the flags registered before the edge.
//
// state   | meaning
// RUN     | pc advances or redirects every cycle
// WAIT_IN | IN instruction pending; pc held until inAck
// HALT    | halted; pc held until resume
module pc_sequencer #(
  parameter int                  PC_WIDTH   = pc_sequencer_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] mainAddress,
  input  logic                jump,
  input  logic                bzero,
  input  logic                bnegative,
  input  logic                HLT,
  input  logic                enable,
  input  logic                aluZero,
  input  logic                aluNegative,
  input  logic                inRequest,
  input  logic                inAck,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                stall,
  output logic                zeroFlag,
  output logic                negativeFlag
);

  import pc_sequencer_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                zero_flag;
  logic                negative_flag;

  flagRegister u_flags (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .zero_in      (aluZero),
    .negative_in  (aluNegative),
    .zero_out     (zero_flag),
    .negative_out (negative_flag)
  );

  // Natural wrap modulo 2^PC_WIDTH.
  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (HLT) begin
          state_d = HALT;
        end else if (jump) begin
          pc_d = mainAddress;
        end else if (inRequest) begin
          state_d = WAIT_IN;
        end else if (bzero && zero_flag) begin
          pc_d = mainAddress;
        end else if (bnegative && negative_flag) begin
          pc_d = mainAddress;
        end else begin
          pc_d = pc_inc;
        end
      end
      WAIT_IN: begin
        if (inAck) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc           = pc_q;
  assign halted       = (state_q == HALT);
  assign stall        = (state_q == WAIT_IN);
  assign zeroFlag     = zero_flag;
  assign negativeFlag = negative_flag;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues hand-computed expectations,
// a monitor compares them against the DUT on the falling edge.
module tb_pc_sequencer;

  logic       clock;
  logic       reset;
  logic [9:0] mainAddress;
  logic       jump, bzero, bnegative, HLT, enable;
  logic       aluZero, aluNegative, inRequest, inAck, resume;
  logic [9:0] pc;
  logic       halted, stall, zeroFlag, negativeFlag;

  typedef struct packed {
    logic [9:0] pc;
    logic       halted;
    logic       stall;
    logic       z;
    logic       n;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  pc_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .mainAddress  (mainAddress),
    .jump         (jump),
    .bzero        (bzero),
    .bnegative    (bnegative),
    .HLT          (HLT),
    .enable       (enable),
    .aluZero      (aluZero),
    .aluNegative  (aluNegative),
    .inRequest    (inRequest),
    .inAck        (inAck),
    .resume       (resume),
    .pc           (pc),
    .halted       (halted),
    .stall        (stall),
    .zeroFlag     (zeroFlag),
    .negativeFlag (negativeFlag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input string nm, input int p, input logic h, input logic s,
                      input logic z, input logic n);
    exp_t e;
    e.pc     = p[9:0];
    e.halted = h;
    e.stall  = s;
    e.z      = z;
    e.n      = n;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    mainAddress = '0;
    jump = 0; bzero = 0; bnegative = 0; HLT = 0; enable = 0;
    aluZero = 0; aluNegative = 0; inRequest = 0; inAck = 0; resume = 0;
  endtask

  // Monitor: registered outputs are stable on the falling edge.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {pc, halted, stall, zeroFlag, negativeFlag};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got pc=%0d halted=%b stall=%b z=%b n=%b, expected pc=%0d halted=%b stall=%b z=%b n=%b",
                   nm, act.pc, act.halted, act.stall, act.z, act.n,
                   e.pc, e.halted, e.stall, e.z, e.n);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    idle();
    reset = 1'b0;
    #2 push("reset_state", 0, 0, 0, 0, 0);
    @(negedge clock) reset = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      @(posedge clock) push("count", i, 0, 0, 0, 0);
    end

    @(negedge clock) begin jump = 1; mainAddress = 10'd1022; end
    @(posedge clock) push("jmp_1022", 1022, 0, 0, 0, 0);
    @(negedge clock) idle();
    @(posedge clock) push("run_1023", 1023, 0, 0, 0, 0);
    @(posedge clock) push("wrap_0", 0, 0, 0, 0, 0);

    @(negedge clock) begin enable = 1; aluZero = 1; end
    @(posedge clock) push("load_z", 1, 0, 0, 1, 0);
    @(negedge clock) begin idle(); bzero = 1; mainAddress = 10'h2A; end
    @(posedge clock) push("bz_taken", 42, 0, 0, 1, 0);
    @(negedge clock) begin idle(); enable = 1; aluZero = 0; end
    @(posedge clock) push("clear_z", 43, 0, 0, 0, 0);
    @(negedge clock) begin idle(); bzero = 1; mainAddress = 10'h2A; end
    @(posedge clock) push("bz_not_taken", 44, 0, 0, 0, 0);

    @(negedge clock) begin idle(); enable = 1; aluNegative = 1; bnegative = 1; mainAddress = 10'h100; end
    @(posedge clock) push("bn_old_flag", 45, 0, 0, 0, 1);
    @(negedge clock) begin idle(); bnegative = 1; mainAddress = 10'h100; end
    @(posedge clock) push("bn_taken", 256, 0, 0, 0, 1);

    @(negedge clock) begin idle(); jump = 1; inRequest = 1; mainAddress = 10'd7; end
    @(posedge clock) push("jump_over_in", 7, 0, 0, 0, 1);

    @(negedge clock) begin idle(); HLT = 1; jump = 1; mainAddress = 10'h55; end
    @(posedge clock) push("hlt_enter", 7, 1, 0, 0, 1);
    @(negedge clock) begin
      idle(); HLT = 1; jump = 1; inRequest = 1; bnegative = 1; inAck = 1;
      mainAddress = 10'h55; enable = 1; aluZero = 1; aluNegative = 1;
    end
    @(posedge clock) push("hlt_ignore", 7, 1, 0, 1, 1);
    @(negedge clock) begin idle(); resume = 1; end
    @(posedge clock) push("resume", 8, 0, 0, 1, 1);
    @(negedge clock) begin idle(); resume = 1; end
    @(posedge clock) push("resume_in_run", 9, 0, 0, 1, 1);

    @(negedge clock) begin idle(); jump = 1; mainAddress = 10'd2; end
    @(posedge clock) push("jmp_2", 2, 0, 0, 1, 1);
    @(negedge clock) idle();
    @(posedge clock) push("run_3", 3, 0, 0, 1, 1);
    @(negedge clock) begin idle(); inRequest = 1; bzero = 1; mainAddress = 10'h2A; end
    @(posedge clock) push("in_req", 3, 0, 1, 1, 1);
    @(negedge clock) idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock) push("wait_hold", 3, 0, 1, 1, 1);
    end
    @(negedge clock) begin idle(); inAck = 1; end
    @(posedge clock) push("in_ack", 4, 0, 0, 1, 1);
    @(negedge clock) begin idle(); inAck = 1; end
    @(posedge clock) push("ack_in_run", 5, 0, 0, 1, 1);

    @(negedge clock) begin idle(); inRequest = 1; end
    @(posedge clock) push("wait_again", 5, 0, 1, 1, 1);
    @(negedge clock) idle();
    @(posedge clock);
    #2 reset = 1'b0;
    #1 push("async_reset", 0, 0, 0, 0, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock) push("post_reset", 1, 0, 0, 0, 0);
    @(negedge clock) begin idle(); bzero = 1; mainAddress = 10'd9; end
    @(posedge clock) push("post_reset_bz", 2, 0, 0, 0, 0);
    @(negedge clock) idle();

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
